// File: rtl/riscv_pkg.sv
// Shared types for the 16-bit core: instruction classes and memory-stage states.
package riscv_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_LD  = 3'b010,
        OP_ST  = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_SLT = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_t;

    function automatic logic is_mem_op(input op_t o);
        return (o == OP_LD) || (o == OP_ST);
    endfunction

endpackage

// File: rtl/mem_wb_stage.sv
// Memory/write-back stage: one data-memory transaction per load/store over req/gnt/rvalid,
// single-cycle register-file write, back-pressure while busy, timeout abort.
module mem_wb_stage
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] alu_data,
    input  logic [15:0] store_data,
    input  op_t         op,
    input  logic [2:0]  rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata,
    output logic        wb_en,
    output logic [2:0]  wb_rd,
    output logic [15:0] wb_data,
    output logic        mem_err
);

    localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

    mem_state_t  state_q;
    logic [15:0] cnt_q;
    logic [2:0]  rd_q;

    assign in_ready = (state_q == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            rd_q      <= 3'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'd0;
            mem_wdata <= 16'd0;
            wb_en     <= 1'b0;
            wb_rd     <= 3'd0;
            wb_data   <= 16'd0;
            mem_err   <= 1'b0;
        end else begin
            wb_en   <= 1'b0;
            mem_err <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        rd_q <= rd;
                        if (is_mem_op(op)) begin
                            state_q   <= REQ;
                            cnt_q     <= 16'd0;
                            mem_req   <= 1'b1;
                            mem_we    <= (op == OP_ST);
                            mem_addr  <= alu_data;
                            mem_wdata <= store_data;
                        end else begin
                            wb_en   <= (rd != 3'd0);
                            wb_rd   <= rd;
                            wb_data <= alu_data;
                        end
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + 16'd1;
                    // Completion wins over a timeout that lands in the same cycle.
                    if (mem_gnt && (mem_we || mem_rvalid)) begin
                        state_q <= IDLE;
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            wb_en   <= (rd_q != 3'd0);
                            wb_rd   <= rd_q;
                            wb_data <= mem_rdata;
                        end
                    end else if (cnt_q == CntLast) begin
                        state_q <= IDLE;
                        mem_req <= 1'b0;
                        mem_err <= 1'b1;
                    end else if (mem_gnt) begin
                        state_q <= WAIT;
                        mem_req <= 1'b0;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (mem_rvalid) begin
                        state_q <= IDLE;
                        wb_en   <= (rd_q != 3'd0);
                        wb_rd   <= rd_q;
                        wb_data <= mem_rdata;
                    end else if (cnt_q == CntLast) begin
                        state_q <= IDLE;
                        mem_err <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
